if_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue. It holds the fetch PC and runs a single-outstanding request/response interface to instruction memory. Fetched words are buffered together with their PC+4 in a DEPTH-entry FIFO, and the entries are handed to decode over a valid/ready handshake. The stage sits between instruction memory and decode. It supports branch, jump and jump-register redirects with queue flush, and detects the halt instruction precisely at dequeue.

---
 rtl/if_prefetch_unit.sv | 147 ++++++++++++++
 tb/tb_if_prefetch_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// Fetch stage: fetch PC, single-outstanding imem request, DEPTH-entry prefetch queue to decode (IF_PREFETCH_BYPASS_EN adds an empty-queue bypass).
// Latency: response -> out_valid 1 cycle (0 with bypass); redirect -> new request 1 cycle, or 1 cycle after a discarded response.
// Backpressure: decode stalls via out_ready; fetch stops issuing while the queue holds DEPTH entries.
module if_prefetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     HALT_INST = 32'h0000000c
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  input  logic            pc_src,
  input  logic [XLEN-1:0] baddr,
  input  logic            jump,
  input  logic [25:0]     jea,
  input  logic [XLEN-1:0] redirect_pc4,
  input  logic            jump_register,
  input  logic [XLEN-1:0] rs_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc4,
  output logic            halted
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_started;
  logic            r_discard;
  logic            r_halt_pending;
  logic            r_halted;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_q_inst [DEPTH];
  logic [XLEN-1:0] r_q_pc4  [DEPTH];

  logic            w_redirect;
  logic            w_accept;
  logic            w_empty;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_q_pop;
  logic            w_halt_deq;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fetch_pc4;

  // jump_register > jump > pc_src; the J-type target keeps the top nibble of the redirecting PC+4
  always_comb begin
    w_target = baddr;
    if (jump_register)
      w_target = rs_data;
    else if (jump)
      w_target = (redirect_pc4 & ~XLEN'(28'hFFF_FFFF)) | XLEN'({jea, 2'b00});
  end

  assign w_redirect  = jump_register | jump | pc_src;
  assign w_fetch_pc4 = r_fetch_pc + XLEN'(4);
  assign w_empty     = (r_count == '0);

  // The count check reserves a slot so an issued request always has room for its response
  assign inst_req  = r_started && (r_state == RUN) && !r_discard && (r_count < CW'(DEPTH));
  assign inst_addr = r_fetch_pc;
  assign w_accept  = inst_valid && inst_req && !w_redirect;

`ifdef IF_PREFETCH_BYPASS_EN
  assign w_bypass  = w_accept && w_empty;
  assign out_inst  = w_bypass ? inst : r_q_inst[r_rd_ptr];
  assign out_pc4   = w_bypass ? w_fetch_pc4 : r_q_pc4[r_rd_ptr];
`else
  assign w_bypass  = 1'b0;
  assign out_inst  = r_q_inst[r_rd_ptr];
  assign out_pc4   = r_q_pc4[r_rd_ptr];
`endif

  assign out_valid  = !w_empty || w_bypass;
  assign w_pop      = out_valid && out_ready;
  assign w_q_pop    = w_pop && !w_empty;
  assign w_push     = w_accept && !(w_bypass && out_ready);
  assign w_halt_deq = w_pop && (out_inst == HALT_INST) && (r_halt_pending || w_bypass);
  assign halted     = r_halted;

  always_ff @(posedge clk) begin
    if (rst_b && w_push) begin
      r_q_inst[r_wr_ptr] <= inst;
      r_q_pc4[r_wr_ptr]  <= w_fetch_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state        <= RUN;
      r_fetch_pc     <= RESET_PC;
      r_started      <= 1'b0;
      r_discard      <= 1'b0;
      r_halt_pending <= 1'b0;
      r_halted       <= 1'b0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
    end else begin
      r_started <= 1'b1;
      if (w_redirect) begin
        r_rd_ptr       <= '0;
        r_wr_ptr       <= '0;
        r_count        <= '0;
        r_fetch_pc     <= w_target;
        r_halt_pending <= 1'b0;
        // A request still in flight must have its eventual response dropped
        r_discard      <= (r_discard || inst_req) && !inst_valid;
        if (r_state != HALTED)
          r_state <= RUN;
      end else begin
        if (inst_valid && r_discard)
          r_discard <= 1'b0;
        if (w_push)
          r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_q_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_q_pop)
          r_count <= r_count + 1'b1;
        else if (!w_push && w_q_pop)
          r_count <= r_count - 1'b1;
        if (w_accept)
          r_fetch_pc <= w_fetch_pc4;
        if (w_halt_deq) begin
          r_state        <= HALTED;
          r_halted       <= 1'b1;
          r_halt_pending <= 1'b0;
        end else if (w_accept && (inst == HALT_INST) && (r_state == RUN)) begin
          r_state        <= DRAIN;
          r_halt_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: latency-programmable instruction memory plus a queue-level reference model.
module tb_if_prefetch_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] HALT     = 32'h0000000c;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic        pc_src;
  logic [31:0] baddr;
  logic        jump;
  logic [25:0] jea;
  logic [31:0] redirect_pc4;
  logic        jump_register;
  logic [31:0] rs_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc4;
  logic        halted;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  if_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .HALT_INST(HALT)) dut (
    .clk(clk), .rst_b(rst_b), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_valid(inst_valid), .inst(inst), .pc_src(pc_src), .baddr(baddr),
    .jump(jump), .jea(jea), .redirect_pc4(redirect_pc4), .jump_register(jump_register),
    .rs_data(rs_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc4(out_pc4), .halted(halted)
  );

  // ---------------- instruction memory model ----------------
  int unsigned lat       = 0;
  logic        mem_busy  = 1'b0;
  int unsigned mem_cnt   = 0;
  logic [31:0] mem_addr  = 32'h0;
  logic [31:0] halt_addr = 32'h2;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == halt_addr) return HALT;
    return {a[15:0] ^ 16'h5a5a, a[15:0]};
  endfunction

  assign inst_valid = (lat == 0) ? inst_req : (mem_busy && mem_cnt == 0);
  assign inst       = word_at((lat == 0) ? inst_addr : mem_addr);

  always @(posedge clk) begin
    if (lat == 0) begin
      mem_busy <= 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt == 0) mem_busy <= 1'b0;
      else mem_cnt <= mem_cnt - 1;
    end else if (inst_req) begin
      mem_busy <= 1'b1;
      mem_addr <= inst_addr;
      mem_cnt  <= lat - 1;
    end
  end

  // ---------------- reference model: queue of fetched PCs ----------------
  logic [31:0] q[$];
  logic [31:0] exp_req;
  logic        exp_drain;
  logic        exp_halted;
  logic        redir;
  logic [31:0] tgt;
  int          sb_bad  = 0;
  int          acc_cnt = 0;
  int          del_cnt = 0;

  task automatic sb_err(input string what);
    sb_bad++;
    if (sb_bad < 8)
      $display("sb: %s disagrees with model at t=%0t (req=%b addr=%h exp_req=%h ov=%b pc4=%h entries=%0d)",
               what, $time, inst_req, inst_addr, exp_req, out_valid, out_pc4, q.size());
  endtask

  always @(negedge clk) begin
    if (!rst_b) begin
      q.delete();
      exp_req    = RESET_PC;
      exp_drain  = 1'b0;
      exp_halted = 1'b0;
    end else begin
      redir = jump_register | jump | pc_src;
      tgt   = jump_register ? rs_data : jump ? {redirect_pc4[31:28], jea, 2'b00} : baddr;
      if (halted !== exp_halted) sb_err("halted");
      if (out_valid !== (q.size() != 0)) sb_err("out_valid");
      if (inst_req === 1'b1 && (exp_drain || exp_halted || q.size() >= DEPTH || inst_addr !== exp_req))
        sb_err("request");
      if (out_valid && out_ready && q.size() != 0) begin
        if (out_pc4 !== q[0] + 32'd4 || out_inst !== word_at(q[0])) sb_err("head entry");
        if (!redir && word_at(q[0]) == HALT) exp_halted = 1'b1;
        void'(q.pop_front());
        del_cnt++;
      end
      if (redir) begin
        q.delete();
        exp_req   = tgt;
        exp_drain = 1'b0;
      end else if (inst_valid && inst_req) begin
        q.push_back(exp_req);
        if (word_at(exp_req) == HALT) exp_drain = 1'b1;
        exp_req = exp_req + 32'd4;
        acc_cnt++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset(input int unsigned l);
    cyc();
    rst_b = 1'b0; pc_src = 1'b0; jump = 1'b0; jump_register = 1'b0;
    lat = l;
    repeat (5) cyc();
    rst_b = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    out_ready = 1'b1; lat = 0;
    repeat (3) cyc();
    settle();
    n_checks++; if (inst_req !== 1'b0) $display("FAIL reset_req got=%b want=0", inst_req); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b want=0", halted); else n_pass++;
    n_checks++; if (inst_addr !== RESET_PC) $display("FAIL reset_addr got=%h want=%h", inst_addr, RESET_PC); else n_pass++;
    rst_b = 1'b1;
    settle();
    n_checks++; if (inst_req !== 1'b0) $display("FAIL reset_release_req got=%b want=0", inst_req); else n_pass++;
    cyc(); settle();
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== RESET_PC)
      $display("FAIL reset_first_req got=%b/%h want=1/%h", inst_req, inst_addr, RESET_PC); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset(0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(); settle();
      if (k < 3) begin
        n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'(4 * k))
          $display("FAIL stream_req%0d got=%b/%h want=1/%h", k, inst_req, inst_addr, 32'(4 * k)); else n_pass++;
      end
      if (k >= 1) begin
        n_checks++; if (out_valid !== 1'b1 || out_pc4 !== 32'(4 * k))
          $display("FAIL stream_pc4_%0d got=%b/%h want=1/%h", k, out_valid, out_pc4, 32'(4 * k)); else n_pass++;
      end
    end
    n_checks++; if (halted !== 1'b0) $display("FAIL stream_halted got=%b want=0", halted); else n_pass++;
  endtask

  task automatic test_backpressure();
    int a0;
    do_reset(0);
    out_ready = 1'b0;
    a0 = acc_cnt;
    repeat (8) cyc();
    settle();
    n_checks++; if (acc_cnt - a0 !== 4) $display("FAIL full_accepts got=%0d want=4", acc_cnt - a0); else n_pass++;
    n_checks++; if (inst_req !== 1'b0) $display("FAIL full_req got=%b want=0", inst_req); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || out_pc4 !== 32'h4)
      $display("FAIL full_head got=%b/%h want=1/00000004", out_valid, out_pc4); else n_pass++;
    out_ready = 1'b1;
    cyc(); settle();
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h10)
      $display("FAIL full_resume got=%b/%h want=1/00000010", inst_req, inst_addr); else n_pass++;
  endtask

  task automatic test_jump_flush();
    int n = 0;
    bit stale = 0;
    do_reset(3);
    out_ready = 1'b1;
    cyc(); settle();
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h0)
      $display("FAIL jump_first_req got=%b/%h want=1/00000000", inst_req, inst_addr); else n_pass++;
    cyc();
    jump = 1'b1; redirect_pc4 = 32'h1000_0004; jea = 26'h40;
    settle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL jump_queue_empty got=%b want=0", out_valid); else n_pass++;
    cyc();
    jump = 1'b0;
    settle();
    n_checks++; if (inst_req !== 1'b0) $display("FAIL jump_discard_req got=%b want=0", inst_req); else n_pass++;
    while (inst_req !== 1'b1 && n < 20) begin
      cyc(); settle(); n++;
      if (out_valid) stale = 1;
    end
    n_checks++; if (n !== 2) $display("FAIL jump_resume_delay got=%0d want=2", n); else n_pass++;
    n_checks++; if (inst_addr !== 32'h1000_0100) $display("FAIL jump_target got=%h want=10000100", inst_addr); else n_pass++;
    n_checks++; if (stale !== 1'b0) $display("FAIL jump_stale_pushed got=%b want=0", stale); else n_pass++;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin cyc(); settle(); n++; end
    n_checks++; if (out_valid !== 1'b1 || out_pc4 !== 32'h1000_0104)
      $display("FAIL jump_first_out got=%b/%h want=1/10000104", out_valid, out_pc4); else n_pass++;
  endtask

  task automatic test_priority();
    int n = 0;
    do_reset(1);
    out_ready = 1'b0;
    repeat (6) cyc();
    jump_register = 1'b1; jump = 1'b1; pc_src = 1'b1;
    rs_data = 32'h200; baddr = 32'h80; jea = 26'h40; redirect_pc4 = 32'h3000_0000;
    cyc();
    jump_register = 1'b0; jump = 1'b0; pc_src = 1'b0;
    settle();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL prio_flush got=%b want=0", out_valid); else n_pass++;
    while (inst_req !== 1'b1 && n < 10) begin cyc(); settle(); n++; end
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h200)
      $display("FAIL prio_jr got=%b/%h want=1/00000200", inst_req, inst_addr); else n_pass++;
    out_ready = 1'b1;
    repeat (5) cyc();
    jump = 1'b1; pc_src = 1'b1; jea = 26'h123; redirect_pc4 = 32'h5000_0000; baddr = 32'h80;
    cyc();
    jump = 1'b0; pc_src = 1'b0;
    settle();
    n = 0;
    while (inst_req !== 1'b1 && n < 10) begin cyc(); settle(); n++; end
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h5000_048c)
      $display("FAIL prio_jump got=%b/%h want=1/5000048c", inst_req, inst_addr); else n_pass++;
  endtask

  task automatic test_halt();
    bit saw24 = 0, got = 0;
    int n = 0, b0;
    halt_addr = 32'h20;
    do_reset(0);
    b0 = sb_bad;
    while (!got && n < 80) begin
      cyc();
      out_ready = 1'($urandom_range(0, 1));
      settle(); n++;
      if (inst_req && inst_addr == 32'h24) saw24 = 1;
      if (out_valid && out_ready && out_pc4 == 32'h24) begin
        got = 1;
        n_checks++; if (halted !== 1'b0) $display("FAIL halt_early got=%b want=0", halted); else n_pass++;
      end
    end
    n_checks++; if (got !== 1'b1) $display("FAIL halt_dequeue_seen got=%b want=1", got); else n_pass++;
    cyc(); settle();
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_rise got=%b want=1", halted); else n_pass++;
    out_ready = 1'b1;
    repeat (5) cyc();
    settle();
    n_checks++; if (halted !== 1'b1 || inst_req !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL halt_sticky got=%b/%b/%b want=1/0/0", halted, inst_req, out_valid); else n_pass++;
    n_checks++; if (saw24 !== 1'b0) $display("FAIL halt_no_req24 got=%b want=0", saw24); else n_pass++;
    n_checks++; if (sb_bad !== b0) $display("FAIL halt_model got=%0d want=%0d", sb_bad, b0); else n_pass++;
  endtask

  task automatic test_halt_redirect();
    int n = 0;
    halt_addr = 32'h20;
    do_reset(0);
    out_ready = 1'b1;
    while (!(inst_req && inst_valid && inst_addr == 32'h20) && n < 40) begin cyc(); settle(); n++; end
    out_ready = 1'b0;
    n_checks++; if (inst_addr !== 32'h20) $display("FAIL hredir_fetch got=%h want=00000020", inst_addr); else n_pass++;
    cyc();
    pc_src = 1'b1; baddr = 32'h80;
    cyc();
    pc_src = 1'b0; out_ready = 1'b1;
    settle();
    n = 0;
    while (inst_req !== 1'b1 && n < 10) begin cyc(); settle(); n++; end
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h80)
      $display("FAIL hredir_resume got=%b/%h want=1/00000080", inst_req, inst_addr); else n_pass++;
    repeat (10) cyc();
    settle();
    n_checks++; if (halted !== 1'b0) $display("FAIL hredir_halted got=%b want=0", halted); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    halt_addr = 32'h2;
    do_reset(3);
    out_ready = 1'b1;
    while (!(inst_req && inst_addr == 32'h8 && !inst_valid) && n < 30) begin cyc(); settle(); n++; end
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'h8)
      $display("FAIL rmid_inflight got=%b/%h want=1/00000008", inst_req, inst_addr); else n_pass++;
    cyc(); rst_b = 1'b0;
    cyc();
    cyc(); rst_b = 1'b1;
    settle();
    n_checks++; if (inst_req !== 1'b0 || out_valid !== 1'b0 || halted !== 1'b0 || inst_addr !== RESET_PC)
      $display("FAIL rmid_reset_vals got=%b/%b/%b/%h want=0/0/0/%h", inst_req, out_valid, halted, inst_addr, RESET_PC);
    else n_pass++;
    cyc(); settle();
    n_checks++; if (inst_req !== 1'b1 || inst_addr !== RESET_PC || out_valid !== 1'b0)
      $display("FAIL rmid_first_req got=%b/%h/%b want=1/%h/0", inst_req, inst_addr, out_valid, RESET_PC); else n_pass++;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin cyc(); settle(); n++; end
    n_checks++; if (out_valid !== 1'b1 || out_pc4 !== RESET_PC + 32'd4 || out_inst !== word_at(RESET_PC))
      $display("FAIL rmid_first_out got=%b/%h/%h want=1/%h/%h", out_valid, out_pc4, out_inst, RESET_PC + 32'd4, word_at(RESET_PC));
    else n_pass++;
  endtask

  task automatic test_random();
    int b0, d0;
    halt_addr = 32'h2;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset($urandom_range(0, 3));
      b0 = sb_bad; d0 = del_cnt;
      repeat (400) begin
        cyc();
        out_ready     = ($urandom_range(0, 3) != 0);
        jump_register = ($urandom_range(0, 59) == 0);
        jump          = ($urandom_range(0, 49) == 0);
        pc_src        = ($urandom_range(0, 39) == 0);
        rs_data       = $urandom & 32'hffff_fffc;
        baddr         = $urandom & 32'hffff_fffc;
        redirect_pc4  = $urandom;
        jea           = 26'($urandom);
      end
      cyc();
      jump_register = 1'b0; jump = 1'b0; pc_src = 1'b0;
      settle();
      n_checks++; if (sb_bad !== b0) $display("FAIL random_seg%0d_model got=%0d want=%0d", seg, sb_bad, b0); else n_pass++;
      n_checks++; if (del_cnt - d0 < 50) $display("FAIL random_seg%0d_progress got=%0d want>=50", seg, del_cnt - d0); else n_pass++;
    end
  endtask

  initial begin
    rst_b = 1'b0; out_ready = 1'b0;
    pc_src = 1'b0; jump = 1'b0; jump_register = 1'b0;
    baddr = '0; jea = '0; redirect_pc4 = '0; rs_data = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_flush();
    test_priority();
    test_halt();
    test_halt_redirect();
    test_reset_mid();
    test_random();
    n_checks++; if (sb_bad !== 0) $display("FAIL model_total got=%0d want=0", sb_bad); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
